// File: rtl/uart_packet_rx.sv
// 8N1 UART receiver that hands each byte to the instruction loader over a
// four-phase packet_ready/packet_ack handshake, with a one-byte pending slot.
module uart_packet_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       packet_ack,
  output logic       packet_ready,
  output logic [7:0] uart_packet,
  output logic       rx_busy,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_shreg;
  logic                   r_pending;
  logic                   w_bit_done;
  logic                   w_deliver;
  logic                   w_occupied;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rxs      = r_sync[SYNC_STAGES-1];
  assign w_bit_done = (r_cnt == BIT_LAST);
  assign w_deliver  = (r_state == S_STOP) && w_bit_done && w_rxs;
  assign w_occupied = packet_ready || r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      rx_busy     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rxs) begin
            r_state  <= S_START;
            r_bitcnt <= '0;
            rx_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_cnt    <= '0;
            r_shreg  <= {w_rxs, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          // Leaving at mid-stop lets the next start edge be caught without slip.
          if (w_bit_done) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              r_state     <= S_BREAK;
              framing_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rxs) begin
            r_state <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      packet_ready <= 1'b0;
      uart_packet  <= '0;
      r_pending    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (packet_ready && packet_ack) begin
        packet_ready <= 1'b0;
      end
      if (r_pending && !packet_ack) begin
        packet_ready <= 1'b1;
        r_pending    <= 1'b0;
      end
      // A byte landing while packet_ready is still high counts as occupied,
      // even in the cycle the handshake is clearing it.
      if (w_deliver) begin
        if (!w_occupied) begin
          uart_packet <= r_shreg;
          if (packet_ack) begin
            r_pending <= 1'b1;
          end else begin
            packet_ready <= 1'b1;
          end
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx at 16 clocks per bit: handshake, back-to-back,
// framing/break, pending slot, overrun, glitch rejection and mid-frame reset.
module tb_uart_packet_rx;

  localparam int unsigned CLKS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       packet_ack = 1'b0;
  logic       packet_ready;
  logic [7:0] uart_packet;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun_err;

  int  total = 0;
  int  bad = 0;
  int  fe_cnt = 0;
  int  ov_cnt = 0;
  int  rise_cnt = 0;
  int  hi_cnt = 0;
  time ov_t = 0;
  time stop_t = 0;
  logic prev_ready = 1'b0;
  bit   stop_phase = 1'b0;

  uart_packet_rx #(
    .CLKS_PER_BIT(CLKS),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .packet_ack  (packet_ack),
    .packet_ready(packet_ready),
    .uart_packet (uart_packet),
    .rx_busy     (rx_busy),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (framing_err) fe_cnt++;
    if (overrun_err) begin
      ov_cnt++;
      ov_t = $time;
    end
    if (packet_ready && !prev_ready) rise_cnt++;
    if (packet_ready) hi_cnt++;
    prev_ready = packet_ready;
  end

  task automatic send_frame(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    stop_t     = $time;
    stop_phase = 1'b1;
    rx         = stopb;
    repeat (CLKS) @(negedge clk);
    stop_phase = 1'b0;
    rx         = 1'b1;
  endtask

  task automatic loader_take(input int dly, output logic [7:0] b, output bit ok);
    int n;
    ok = 1'b0;
    b  = '0;
    n  = 0;
    while (!packet_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (packet_ready) begin
      b = uart_packet;
      repeat (dly) @(negedge clk);
      packet_ack = 1'b1;
      n = 0;
      while (packet_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      ok = !packet_ready;
      packet_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx = 1'b1;
    packet_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (packet_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", packet_ready); end
    total++; if (uart_packet !== 8'h00) begin bad++; $display("FAIL reset_packet: got %h want 00", uart_packet); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    total++; if ({framing_err, overrun_err} !== 2'b00) begin bad++; $display("FAIL reset_errs: got %b want 00", {framing_err, overrun_err}); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    total++; if ({packet_ready, rx_busy} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: got %b want 00", {packet_ready, rx_busy}); end
  endtask

  task automatic test_single();
    int h0, f0, o0, n;
    logic [7:0] got;
    bit seen, fall_ok;
    seen = 1'b0; fall_ok = 1'b0; got = '0;
    #1;
    h0 = hi_cnt; f0 = fe_cnt; o0 = ov_cnt;
    @(negedge clk);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n = 0;
        while (!packet_ready && n < 400) begin
          @(negedge clk);
          n++;
        end
        seen = packet_ready;
        got  = uart_packet;
        if (seen) begin
          repeat (3) @(negedge clk);
          packet_ack = 1'b1;
          @(posedge clk);
          #1;
          fall_ok = !packet_ready;
          @(negedge clk);
          packet_ack = 1'b0;
        end
      end
    join
    repeat (4) @(negedge clk);
    #1;
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", seen); end
    total++; if (got !== 8'hA5) begin bad++; $display("FAIL single_byte: got %h want a5", got); end
    total++; if (fall_ok !== 1'b1) begin bad++; $display("FAIL single_fall: got %b want 1", fall_ok); end
    total++; if (hi_cnt - h0 !== 4) begin bad++; $display("FAIL single_hi_cycles: got %0d want 4", hi_cnt - h0); end
    total++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin bad++; $display("FAIL single_errs: got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [3];
    logic [7:0] exp [3];
    bit ok [3];
    int n, run, maxlow;
    bit busy_seen;
    exp = '{8'h00, 8'h00, 8'hFF};
    run = 0; maxlow = 0; busy_seen = 1'b0;
    @(negedge clk);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        for (int i = 0; i < 3; i++) loader_take(2, got[i], ok[i]);
      end
      begin
        n = 0;
        while (!rx_busy && n < 50) begin
          @(negedge clk);
          n++;
        end
        busy_seen = rx_busy;
        repeat (460) begin
          @(negedge clk);
          if (!rx_busy) begin
            run++;
            if (run > maxlow) maxlow = run;
          end else begin
            run = 0;
          end
        end
      end
    join
    for (int i = 0; i < 3; i++) begin
      total++; if (ok[i] !== 1'b1) begin bad++; $display("FAIL b2b_handshake%0d: got %b want 1", i, ok[i]); end
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp[i]); end
    end
    total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL b2b_busy_rise: got %b want 1", busy_seen); end
    total++; if (!(maxlow > 0 && maxlow < 16)) begin bad++; $display("FAIL b2b_busy_gap: got %0d want 1..15", maxlow); end
  endtask

  task automatic test_framing();
    int f0, r0;
    logic [7:0] b, got;
    bit ok;
    b = 8'h3C;
    #1;
    f0 = fe_cnt; r0 = rise_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL frame_pulse: got %0d want 1", fe_cnt - f0); end
    total++; if (rise_cnt - r0 !== 0) begin bad++; $display("FAIL frame_no_ready: got %0d want 0", rise_cnt - r0); end
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL frame_break_busy: got %b want 1", rx_busy); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL frame_idle_busy: got %b want 0", rx_busy); end
    repeat (200) @(negedge clk);
    #1;
    total++; if ((rise_cnt - r0) + (fe_cnt - f0) !== 1) begin bad++; $display("FAIL frame_quiet: got %0d want 1", (rise_cnt - r0) + (fe_cnt - f0)); end
    @(negedge clk);
    fork
      send_frame(8'h11, 1'b1);
      loader_take(1, got, ok);
    join
    total++; if ({ok, got} !== {1'b1, 8'h11}) begin bad++; $display("FAIL frame_recover: got %b/%h want 1/11", ok, got); end
  endtask

  task automatic test_pending();
    int o0, n;
    logic [7:0] first, got;
    bit fell, risen_during, pre, post;
    first = '0; got = '0; fell = 1'b0; risen_during = 1'b0; pre = 1'b1; post = 1'b0;
    #1;
    o0 = ov_cnt;
    @(negedge clk);
    fork
      begin
        send_frame(8'h9A, 1'b1);
        send_frame(8'h56, 1'b1);
      end
      begin
        n = 0;
        while (!packet_ready && n < 400) begin @(negedge clk); n++; end
        first = uart_packet;
        n = 0;
        while (stop_phase && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!stop_phase && n < 400) begin @(negedge clk); n++; end
        packet_ack = 1'b1;
        n = 0;
        while (packet_ready && n < 10) begin @(negedge clk); n++; end
        fell = !packet_ready;
        repeat (31) begin
          @(negedge clk);
          if (packet_ready) risen_during = 1'b1;
        end
        pre = packet_ready;
        packet_ack = 1'b0;
        @(negedge clk);
        post = packet_ready;
        got  = uart_packet;
        packet_ack = 1'b1;
        n = 0;
        while (packet_ready && n < 10) begin @(negedge clk); n++; end
        packet_ack = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    #1;
    total++; if (first !== 8'h9A) begin bad++; $display("FAIL pend_first: got %h want 9a", first); end
    total++; if (fell !== 1'b1) begin bad++; $display("FAIL pend_first_fall: got %b want 1", fell); end
    total++; if (risen_during !== 1'b0) begin bad++; $display("FAIL pend_rise_under_ack: got %b want 0", risen_during); end
    total++; if (pre !== 1'b0) begin bad++; $display("FAIL pend_before_drop: got %b want 0", pre); end
    total++; if (post !== 1'b1) begin bad++; $display("FAIL pend_after_drop: got %b want 1", post); end
    total++; if (got !== 8'h56) begin bad++; $display("FAIL pend_byte: got %h want 56", got); end
    total++; if (ov_cnt - o0 !== 0) begin bad++; $display("FAIL pend_overrun: got %0d want 0", ov_cnt - o0); end
  endtask

  task automatic test_overrun();
    int o0, f0, r0;
    time dt;
    #1;
    o0 = ov_cnt; f0 = fe_cnt; r0 = rise_cnt;
    @(negedge clk);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    dt = ov_t - stop_t;
    total++; if (packet_ready !== 1'b1) begin bad++; $display("FAIL ovr_ready: got %b want 1", packet_ready); end
    total++; if (uart_packet !== 8'h12) begin bad++; $display("FAIL ovr_held: got %h want 12", uart_packet); end
    total++; if (ov_cnt - o0 !== 1) begin bad++; $display("FAIL ovr_pulse: got %0d want 1", ov_cnt - o0); end
    total++; if (!(dt >= 100 && dt <= 120)) begin bad++; $display("FAIL ovr_timing: got %0t want 100..120", dt); end
    total++; if ((rise_cnt - r0) + (fe_cnt - f0) !== 1) begin bad++; $display("FAIL ovr_rises: got %0d want 1", (rise_cnt - r0) + (fe_cnt - f0)); end
  endtask

  task automatic test_glitch_reset();
    int o0, f0, r0;
    logic [7:0] b, got;
    bit ok;
    b = 8'h77;
    #1;
    o0 = ov_cnt; f0 = fe_cnt; r0 = rise_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    total++; if ((rise_cnt - r0) + (fe_cnt - f0) + (ov_cnt - o0) !== 0) begin bad++; $display("FAIL glitch_events: got %0d want 0", (rise_cnt - r0) + (fe_cnt - f0) + (ov_cnt - o0)); end
    total++; if ({rx_busy, uart_packet} !== {1'b0, 8'h12}) begin bad++; $display("FAIL glitch_state: got %b/%h want 0/12", rx_busy, uart_packet); end
    @(negedge clk);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = b[3];
    repeat (8) @(negedge clk);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy: got %b want 1", rx_busy); end
    #2;
    rst = 1'b0;
    #1;
    total++; if ({packet_ready, uart_packet, rx_busy, framing_err, overrun_err} !== 12'h000) begin
      bad++; $display("FAIL rst_async_outputs: got %h want 000", {packet_ready, uart_packet, rx_busy, framing_err, overrun_err});
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    fork
      send_frame(8'h88, 1'b1);
      loader_take(1, got, ok);
    join
    repeat (4) @(negedge clk);
    #1;
    total++; if ({ok, got} !== {1'b1, 8'h88}) begin bad++; $display("FAIL rst_next_frame: got %b/%h want 1/88", ok, got); end
    total++; if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin bad++; $display("FAIL rst_no_pulses: got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_pending();
    test_overrun();
    test_glitch_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
- UART receiver feeding the CPU instruction loader.
- Deserialises 8N1 frames from the host serial line into bytes.
- Presents each byte on uart_packet/packet_ready under the loader's four-phase packet_ready/packet_ack handshake.
- Holds one completed byte while the handshake finishes; flags framing and overrun errors.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 8..4095
SYNC_STAGES, 2, metastability flops on rx; legal range 2..3

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserts immediately, deassert synchronous to clk)
rx  input  1  asynchronous serial line, idle high
packet_ack  input  1  from loader; high = byte taken, held until packet_ready falls
packet_ready  output  1  byte valid on uart_packet
uart_packet  output  8  received byte, LSB first on the wire
rx_busy  output  1  high from start-bit detection until the frame ends
framing_err  output  1  one-cycle pulse: stop bit sampled low
overrun_err  output  1  one-cycle pulse: completed byte dropped because the buffer was occupied

Behaviour:
- Reset (rst low): all outputs 0, FSM to IDLE, counters 0, pending flag 0, synchroniser flops set to 1 (idle line).
- rx passes through SYNC_STAGES flops; all decisions use the synchronised value rxs.
- FSM states and transitions:
  - IDLE: rxs==0 -> START, bit counter cleared, rx_busy=1.
  - START: count to CLKS_PER_BIT/2-1 (integer divide), then sample. rxs==1 -> false start, back to IDLE, no pulse. rxs==0 -> DATA, counter reset.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift right into shreg, new bit into bit 7. After the 8th sample -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs==1: deliver byte, go to IDLE in the same cycle (mid-stop resync; back-to-back frames supported).
    - rxs==0: framing_err pulse, byte discarded, go to BREAK.
  - BREAK: wait for rxs==1, then IDLE.
  - rx_busy is low only in IDLE.
- Delivery:
  - Buffer empty (packet_ready==0 and pending==0):
    - packet_ack==0: uart_packet<=byte, packet_ready<=1 on the next edge.
    - packet_ack==1 (previous handshake still closing): byte stored, pending<=1.
  - Buffer occupied: byte dropped, overrun_err pulses; held byte unchanged.
- Handshake:
  - uart_packet is stable while packet_ready==1.
  - packet_ready==1 and packet_ack==1: packet_ready<=0 on the next edge.
  - pending==1 and packet_ack==0: packet_ready<=1, pending<=0 on the next edge. packet_ready never rises while packet_ack is high.
  - Loader throughput is unaffected: one byte takes 10*CLKS_PER_BIT cycles, far longer than the four handshake edges.
- Latency: packet_ready rises 1 cycle after the mid-stop sample (buffer empty, ack low).
- Counter width: clog2(CLKS_PER_BIT)+1; bit counter 3 bits, wraps only via state change.
- Reset mid-frame: frame abandoned, no pulses; held byte lost.
- Simultaneous events:
  - Delivery in the same cycle that packet_ack drops with pending==0 and packet_ready==0 counts as empty with ack low: direct presentation.
  - Delivery in the same cycle that packet_ready clears is treated as occupied (overrun). This is a deliberate conservative rule.
- Glitches shorter than CLKS_PER_BIT/2 on an idle line never produce a byte.

Test Plan:
- Single byte: CLKS_PER_BIT=16, send 0xA5, loader acks 3 cycles after packet_ready -> uart_packet=0xA5, packet_ready high 4 cycles, falls one edge after ack, no error pulses.
- Loader word: send 0x00,0x00,0xFF back-to-back, model loader handshake -> three presentations in order 0x00,0x00,0xFF, rx_busy low between frames for less than 1 bit time.
- Framing: send 0x3C with stop bit forced low, rx held low 40 cycles -> framing_err one pulse, no packet_ready, FSM stays in BREAK until rx high, then 0x11 received correctly.
- Overrun: send 0x12 then 0x34, never ack -> packet_ready stays high with 0x12, overrun_err one pulse at 0x34's stop sample.
- Pending path: hold packet_ack high for 2 bit times after the first handshake while 0x56 completes -> packet_ready rises with 0x56 exactly 1 cycle after ack falls.
- Glitch/reset: 5-cycle low pulse on idle rx -> no output; assert rst mid-DATA of 0x77 -> all outputs 0 immediately, next frame 0x88 received cleanly.
